// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory port: access sizes, stall levels and controller states.
package mem_ctrl_pkg;

   localparam logic [1:0] MEM_BYTE = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_WORD = 2'd2;

   // Level of the global enable (rdy_in).
   localparam logic ChipStall    = 1'b0;
   localparam logic ChipNotStall = 1'b1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

   // Byte count of an access; the unused encoding 3 behaves as a word.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         MEM_BYTE: return 3'd1;
         MEM_HALF: return 3'd2;
         default:  return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response port of the memory controller plus its byte-wide RAM bus.
interface mem_ctrl_if #(
   parameter int unsigned ADDR_W = 32
) ();

   logic              mem_req;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_size;
   logic [31:0]       mem_wdata;
   logic              mem_rdy;
   logic [31:0]       mem_data;
   logic [7:0]        ram_din;
   logic [7:0]        ram_dout;
   logic [ADDR_W-1:0] ram_a;
   logic              ram_wr;

   // Requester and RAM side together.
   modport master (
      output mem_req, mem_wr, mem_addr, mem_size, mem_wdata, ram_din,
      input  mem_rdy, mem_data, ram_dout, ram_a, ram_wr
   );

   modport slave (
      input  mem_req, mem_wr, mem_addr, mem_size, mem_wdata, ram_din,
      output mem_rdy, mem_data, ram_dout, ram_a, ram_wr
   );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory responder: turns one sized read/write request into 1..4
// single-byte RAM accesses and pulses mem_rdy once the access completes.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic      clk_in,
   input  logic      rst_in,
   input  logic      rdy_in,
   mem_ctrl_if.slave bus
);

   state_e            state_q, state_d;
   logic [2:0]        issue_q, issue_d;
   logic [2:0]        cap_q, cap_d;
   logic [2:0]        nbytes_q, nbytes_d;
   logic              wr_q, wr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              pres_q, pres_d;
   logic              flight_q, flight_d;
   logic [31:0]       rbuf_q, rbuf_d;
   logic [ADDR_W-1:0] ram_a_q, ram_a_d;
   logic [7:0]        ram_dout_q, ram_dout_d;
   logic              ram_wr_q, ram_wr_d;
   logic              mem_rdy_q, mem_rdy_d;
   logic [31:0]       mem_data_q, mem_data_d;

   logic       enable, accept, fire, last_issue, busy_done;
   logic [2:0] issue_nxt, cap_nxt;

   assign enable     = (rdy_in == ChipNotStall);
   assign accept     = (state_q == StIdle) && enable && bus.mem_req;
   // pres_q: the RAM bus carries a byte that has not been counted as issued yet.
   assign fire       = (state_q == StBusy) && enable && pres_q;
   assign issue_nxt  = issue_q + 3'd1;
   assign cap_nxt    = cap_q + 3'd1;
   assign last_issue = (issue_nxt == nbytes_q);
   assign busy_done  = wr_q ? (fire && last_issue)
                            : ((cap_q == nbytes_q) || (flight_q && (cap_nxt == nbytes_q)));

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q    <= StIdle;
         issue_q    <= '0;
         cap_q      <= '0;
         nbytes_q   <= '0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         pres_q     <= 1'b0;
         flight_q   <= 1'b0;
         rbuf_q     <= '0;
         ram_a_q    <= '0;
         ram_dout_q <= '0;
         ram_wr_q   <= 1'b0;
         mem_rdy_q  <= 1'b0;
         mem_data_q <= '0;
      end else begin
         state_q    <= state_d;
         issue_q    <= issue_d;
         cap_q      <= cap_d;
         nbytes_q   <= nbytes_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
         pres_q     <= pres_d;
         flight_q   <= flight_d;
         rbuf_q     <= rbuf_d;
         ram_a_q    <= ram_a_d;
         ram_dout_q <= ram_dout_d;
         ram_wr_q   <= ram_wr_d;
         mem_rdy_q  <= mem_rdy_d;
         mem_data_q <= mem_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (enable) begin
         unique case (state_q)
            StIdle:  if (bus.mem_req) state_d = StBusy;
            StBusy:  if (busy_done) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      issue_d    = issue_q;
      cap_d      = cap_q;
      nbytes_d   = nbytes_q;
      wr_d       = wr_q;
      wdata_d    = wdata_q;
      pres_d     = pres_q;
      rbuf_d     = rbuf_q;
      ram_a_d    = ram_a_q;
      ram_dout_d = ram_dout_q;
      ram_wr_d   = ram_wr_q;
      mem_data_d = mem_data_q;
      mem_rdy_d  = 1'b0;
      flight_d   = fire && !wr_q;

      // A byte addressed last cycle lands now, even while paused.
      if (flight_q) begin
         rbuf_d[{cap_q[1:0], 3'b000} +: 8] = bus.ram_din;
         cap_d = cap_nxt;
      end

      if (accept) begin
         nbytes_d   = size_bytes(bus.mem_size);
         wr_d       = bus.mem_wr;
         wdata_d    = bus.mem_wdata;
         issue_d    = '0;
         cap_d      = '0;
         rbuf_d     = '0;
         pres_d     = 1'b1;
         ram_a_d    = bus.mem_addr;
         ram_dout_d = bus.mem_wdata[7:0];
         ram_wr_d   = bus.mem_wr;
      end else if (fire) begin
         issue_d = issue_nxt;
         if (last_issue) begin
            pres_d   = 1'b0;
            ram_wr_d = 1'b0;
         end else begin
            ram_a_d    = ram_a_q + ADDR_W'(1);
            ram_dout_d = wdata_q[{issue_nxt[1:0], 3'b000} +: 8];
         end
      end

      if ((state_q == StBusy) && enable && busy_done) begin
         mem_rdy_d = 1'b1;
         if (!wr_q) mem_data_d = rbuf_d;
      end
   end

   always_comb begin
      bus.mem_rdy  = mem_rdy_q;
      bus.mem_data = mem_data_q;
      bus.ram_a    = ram_a_q;
      bus.ram_dout = ram_dout_q;
      bus.ram_wr   = ram_wr_q && enable;
   end

endmodule
